// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The pipeline side uses the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        EX_MemRead;
  logic [4:0]  EX_RegWriteAddr;
  logic        EX_BranchTaken;
  logic        MEM_MemAccess;
  logic        dmem_ready;

  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_bubble;
  logic        dmem_timeout;
  logic        dmem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegWriteAddr,
           EX_BranchTaken, MEM_MemAccess, dmem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
           memwb_bubble, dmem_timeout, dmem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegWriteAddr,
           EX_BranchTaken, MEM_MemAccess, dmem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
           memwb_bubble, dmem_timeout, dmem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory freeze with timeout, branch flush, load-use stall.
// Optional macro HAZARD_PERF_EN builds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter logic [7:0] WAIT_TIMEOUT = 8'd16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;

  logic       mem_pending;
  logic       freeze;
  logic       timeout;
  logic       flush;
  logic       rs_hit;
  logic       rt_hit;
  logic       load_use;

  logic       pc_we, ifid_we, idex_we, exmem_we;
  logic       ifid_flush, idex_flush, memwb_bubble, dmem_timeout;

  // Hazard classification; freeze outranks flush, which outranks load-use.
  always_comb begin
    mem_pending = hz.MEM_MemAccess && !hz.dmem_ready;
    freeze      = mem_pending && ((state_q == RUN) || (wcnt_q < WAIT_TIMEOUT));
    timeout     = mem_pending && (state_q == MEM_WAIT) && (wcnt_q >= WAIT_TIMEOUT);
    flush       = !freeze && hz.EX_BranchTaken;
    rs_hit      = (hz.EX_RegWriteAddr == hz.ID_Rs);
    rt_hit      = hz.ID_UsesRt && (hz.EX_RegWriteAddr == hz.ID_Rt);
    load_use    = !freeze && !flush && hz.EX_MemRead &&
                  (hz.EX_RegWriteAddr != 5'd0) && (rs_hit || rt_hit);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q || timeout;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wcnt_d  = 8'd1;
        end else begin
          wcnt_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        // Leaving on ready, timeout or a withdrawn access all return to RUN.
        if (freeze) begin
          wcnt_d  = wcnt_q + 8'd1;
        end else begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    dmem_timeout = timeout;
    if (!rst_n) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      dmem_timeout = 1'b0;
    end else if (freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (flush) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID for one cycle while a bubble enters EX.
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  assign hz.pc_we        = pc_we;
  assign hz.ifid_we      = ifid_we;
  assign hz.idex_we      = idex_we;
  assign hz.exmem_we     = exmem_we;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.dmem_timeout = dmem_timeout;
  assign hz.dmem_err     = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze || load_use) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl, checked against a behavioural model
// that tracks only the length of the current memory stall and the sticky error flag.
module tb_hazard_ctrl;

  localparam int WT = 4;

  logic clk;
  logic rst_n;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.WAIT_TIMEOUT(8'(WT))) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          stalled = 0;
  bit          err_m = 1'b0;
  logic [31:0] stall_m = 32'd0;
  logic [31:0] flush_m = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic ex_rd, input logic [4:0] ex_dst, input logic br,
                        input logic acc, input logic rdy);
    hif.ID_Rs           = rs;
    hif.ID_Rt           = rt;
    hif.ID_UsesRt       = uses_rt;
    hif.EX_MemRead      = ex_rd;
    hif.EX_RegWriteAddr = ex_dst;
    hif.EX_BranchTaken  = br;
    hif.MEM_MemAccess   = acc;
    hif.dmem_ready      = rdy;
  endtask

  task automatic model_reset();
    stalled = 0;
    err_m   = 1'b0;
    stall_m = 32'd0;
    flush_m = 32'd0;
  endtask

  // Entered at posedge+1; checks at posedge+2, then advances the model over the next edge.
  task automatic do_cycle(input string tag);
    bit fz, to, fl, lu;
    logic [8:0] exp_ctl;
    logic [8:0] obs_ctl;
    #1;
    fz = hif.MEM_MemAccess && !hif.dmem_ready && (stalled < WT);
    to = hif.MEM_MemAccess && !hif.dmem_ready && (stalled >= WT);
    fl = !fz && hif.EX_BranchTaken;
    lu = !fz && !fl && hif.EX_MemRead && (hif.EX_RegWriteAddr != 5'd0) &&
         ((hif.EX_RegWriteAddr == hif.ID_Rs) ||
          (hif.ID_UsesRt && (hif.EX_RegWriteAddr == hif.ID_Rt)));
    if (!rst_n) begin
      exp_ctl = 9'd0;
    end else begin
      exp_ctl = {!(fz || lu), !(fz || lu), !fz, !fz, fl, fl || lu, fz, to, err_m};
    end
    obs_ctl = {hif.pc_we, hif.ifid_we, hif.idex_we, hif.exmem_we, hif.ifid_flush,
               hif.idex_flush, hif.memwb_bubble, hif.dmem_timeout, hif.dmem_err};
    $display("cycle %-14s ctl=%09b exp=%09b stall_cnt=%0d flush_cnt=%0d",
             tag, obs_ctl, exp_ctl, hif.stall_cnt, hif.flush_cnt);
    chk({tag, ".ctl"}, 32'(obs_ctl), 32'(exp_ctl));
    chk({tag, ".stall_cnt"}, hif.stall_cnt, stall_m);
    chk({tag, ".flush_cnt"}, hif.flush_cnt, flush_m);
    @(posedge clk);
    if (rst_n) begin
      if (to) err_m = 1'b1;
      stalled = fz ? stalled + 1 : 0;
`ifdef HAZARD_PERF_EN
      if ((fz || lu) && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      if (fl && flush_m != 32'hFFFF_FFFF) flush_m = flush_m + 32'd1;
`endif
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    do_cycle("reset0");
    do_cycle("reset1");
    rst_n = 1'b1;

    set_in(5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    do_cycle("lu_rs");
    set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    do_cycle("lu_after");
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    do_cycle("lu_zero");
    set_in(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    do_cycle("rt_unused");
    set_in(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    do_cycle("lu_rt");
    set_in(5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    do_cycle("br_lu");

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle("mw_wait");
    hif.dmem_ready = 1'b1;
    do_cycle("mw_done");
    hif.dmem_ready = 1'b0;
    do_cycle("mw_fresh");
    set_in(5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    do_cycle("fz_prio");
    hif.dmem_ready = 1'b1;
    do_cycle("fz_release");

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) do_cycle("to_wait");
    hif.dmem_ready = 1'b1;
    do_cycle("to_done");

    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
      do_cycle("rand");
    end

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    do_cycle("pre_rst_a");
    do_cycle("pre_rst_b");
    rst_n = 1'b0;
    model_reset();
    do_cycle("rst_mid");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) do_cycle("post_rst");
    hif.dmem_ready = 1'b1;
    do_cycle("post_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: WAIT_TIMEOUT, default 8'd16 (legal range 1..255), max freeze cycles waiting on dmem_ready before forced release.
REQ-002 clk  input  1  pipeline clock, all state on rising edge.
REQ-003 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 ID_Rs, ID_Rt  input  5 each  source registers of instruction in ID.
REQ-005 ID_UsesRt  input  1  ID instruction reads Rt (R-type, store, beq/bne).
REQ-006 EX_MemRead  input  1  instruction in EX is a load.
REQ-007 EX_RegWriteAddr  input  5  destination of instruction in EX.
REQ-008 EX_BranchTaken  input  1  branch/jump resolved taken in EX.
REQ-009 MEM_MemAccess  input  1  MEM-stage instruction accesses data memory.
REQ-010 dmem_ready  input  1  data memory completes access this cycle.
REQ-011 pc_we, ifid_we, idex_we, exmem_we  output  1 each  stage register write enables.
REQ-012 ifid_flush, idex_flush, memwb_bubble  output  1 each  insert NOP into IF/ID, ID/EX, MEM/WB.
REQ-013 dmem_timeout  output  1  one-cycle pulse on forced release; dmem_err  output  1  sticky timeout flag.
REQ-014 stall_cnt, flush_cnt  output  32 each  performance counters (only with HAZARD_PERF_EN).

Function
REQ-015 FSM states RUN, MEM_WAIT; 8-bit wait counter wcnt.
REQ-016 freeze = MEM_MemAccess && !dmem_ready && (state==RUN || wcnt < WAIT_TIMEOUT).
REQ-017 Freeze (highest priority): pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, ifid_flush=idex_flush=0.
REQ-018 RUN -> MEM_WAIT when freeze; wcnt loads 1 on entry, increments each MEM_WAIT cycle with !dmem_ready.
REQ-019 MEM_WAIT -> RUN when dmem_ready=1; freeze drops combinationally in that same cycle, pipeline advances.
REQ-020 MEM_WAIT with wcnt==WAIT_TIMEOUT and !dmem_ready: no freeze, dmem_timeout=1 that cycle, dmem_err set, -> RUN, wcnt=0.
REQ-021 Flush (no freeze, EX_BranchTaken=1): ifid_flush=1, idex_flush=1, all write enables 1; load-use ignored.
REQ-022 Load-use (no freeze, no flush): EX_MemRead && EX_RegWriteAddr!=0 && (EX_RegWriteAddr==ID_Rs || (ID_UsesRt && EX_RegWriteAddr==ID_Rt)) -> pc_we=0, ifid_we=0, idex_flush=1, idex_we=1, exmem_we=1.
REQ-023 Otherwise all write enables 1, all flushes/bubble 0.
REQ-024 Load-use stall is exactly one cycle per hazard; detection is combinational, no registered latency.
REQ-025 dmem_err clears only on reset.

Reset
REQ-026 rst_n=0 asynchronously: state=RUN, wcnt=0, dmem_err=0, counters=0.
REQ-027 While rst_n=0: all write enables, flushes, memwb_bubble, dmem_timeout forced 0.
REQ-028 Reset during MEM_WAIT abandons the wait; first cycle after release evaluates from RUN.

Configuration
REQ-029 Macro HAZARD_PERF_EN defined: stall_cnt increments each freeze or load-use cycle, flush_cnt each flush cycle, both saturate at 32'hFFFFFFFF.
REQ-030 Macro HAZARD_PERF_EN undefined: counter registers not built, stall_cnt and flush_cnt tied to 0.

Verification
REQ-031 EX load to $t1, ID add reads $t1 as Rs -> one cycle pc_we=0, ifid_we=0, idex_flush=1, then all enables 1.
REQ-032 EX load to $0, ID reads $0 -> no stall, all enables 1.
REQ-033 EX_BranchTaken=1 with simultaneous load-use match -> ifid_flush=idex_flush=1, pc_we=1, no stall; flush_cnt +1 (perf on).
REQ-034 MEM_MemAccess=1, dmem_ready low 3 cycles then high -> 3 freeze cycles with memwb_bubble=1, advance on 4th, state RUN.
REQ-035 WAIT_TIMEOUT=4, dmem_ready never asserted -> freeze 4 cycles, then dmem_timeout pulse, dmem_err=1, enables 1.
REQ-036 rst_n low mid MEM_WAIT -> outputs 0 immediately, state RUN, dmem_err=0, counters 0.
